// File: rtl/uart_tx_fsm_if.sv
// Frame request / serializer / line bundle shared by the UART TX sequencer and its neighbours.
// Latency: none (wires only).
// Backpressure: busy is the only flow control; data_valid is honoured only while busy is low.
//
// Signals:
//   data_valid  request to start a frame with p_data
//   p_data      parallel word (only its parity is used by the sequencer)
//   par_en      insert a parity bit in this frame
//   par_typ     0 = even parity, 1 = odd parity
//   ser_data    current serial bit from the serializer, LSB first
//   ser_en      serializer shift enable
//   busy        frame in progress
//   tx_out      UART line, idle high
//
// master: the client side (word source plus serializer); slave: the sequencer.
interface uart_tx_fsm_if #(
    parameter int WIDTH = 8
);
    logic             data_valid;
    logic [WIDTH-1:0] p_data;
    logic             par_en;
    logic             par_typ;
    logic             ser_data;
    logic             ser_en;
    logic             busy;
    logic             tx_out;

    modport master (
        output data_valid,
        output p_data,
        output par_en,
        output par_typ,
        output ser_data,
        input  ser_en,
        input  busy,
        input  tx_out
    );

    modport slave (
        input  data_valid,
        input  p_data,
        input  par_en,
        input  par_typ,
        input  ser_data,
        output ser_en,
        output busy,
        output tx_out
    );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART TX frame sequencer: start, WIDTH data bits from the serializer, optional parity, stop.
// Latency: start bit on the line the cycle after the accept edge; WIDTH+2+par_en busy cycles.
// Backpressure: no queuing; data_valid is ignored while busy, at least one idle cycle between frames.
//
// Ports:
//   clk   system clock, one cycle per bit period (baud strobe gates it upstream)
//   rst   asynchronous active-low reset; line returns high at once
//   bus   uart_tx_fsm_if.slave (data_valid, p_data, par_en, par_typ, ser_data in;
//         ser_en, busy, tx_out out)
module uart_tx_fsm #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fsm_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic             par_bit_r;
    logic             par_en_r;
    logic             accept;
    logic             last_bit;
    logic             tx_line;

    assign accept   = (state == IDLE) && bus.data_valid;
    assign last_bit = (bit_cnt == LAST_BIT);

    // Next state. Unused encodings fall back to IDLE so a corrupted state
    // register recovers within one edge.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? START : IDLE;
            START:   state_nxt = DATA;
            DATA: begin
                if (last_bit) begin
                    state_nxt = par_en_r ? PARITY : STOP;
                end else begin
                    state_nxt = DATA;
                end
            end
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The counter only moves in DATA and clears on the last data bit, so it
    // is already zero when the next frame reaches DATA.
    always_comb begin
        bit_cnt_nxt = '0;
        if ((state == DATA) && !last_bit) begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            par_bit_r <= 1'b0;
            par_en_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            // Parity options are captured with the word so mid-frame input
            // changes cannot alter the frame on the line.
            if (accept) begin
                par_en_r  <= bus.par_en;
                par_bit_r <= (^bus.p_data) ^ bus.par_typ;
            end
        end
    end

    // Line mux driven only by registered state, so reset forces the line
    // high without waiting for a clock.
    always_comb begin
        tx_line = 1'b1;
        case (state)
            IDLE:    tx_line = 1'b1;
            START:   tx_line = 1'b0;
            DATA:    tx_line = bus.ser_data;
            PARITY:  tx_line = par_bit_r;
            STOP:    tx_line = 1'b1;
            default: tx_line = 1'b1;
        endcase
    end

    assign bus.tx_out = tx_line;
    assign bus.busy   = (state != IDLE);
    assign bus.ser_en = (state == DATA);

endmodule

// File: tb/tb_uart_tx_fsm.sv
module tb_uart_tx_fsm;

    logic clk;
    logic rst;

    uart_tx_fsm_if #(.WIDTH(8)) bus8 ();
    uart_tx_fsm_if #(.WIDTH(5)) bus5 ();

    uart_tx_fsm #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    uart_tx_fsm #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Serializer models: load on the accept edge, shift on ser_en edges, LSB first.
    logic [7:0] sh8;
    logic [4:0] sh5;

    always @(posedge clk) begin
        if (rst && !bus8.busy && bus8.data_valid) sh8 <= bus8.p_data;
        else if (bus8.ser_en)                     sh8 <= sh8 >> 1;
    end

    always @(posedge clk) begin
        if (rst && !bus5.busy && bus5.data_valid) sh5 <= bus5.p_data;
        else if (bus5.ser_en)                     sh5 <= sh5 >> 1;
    end

    assign bus8.ser_data = sh8[0];
    assign bus5.ser_data = sh5[0];

    // Scoreboard: per-cycle {tx_out, ser_en}, per-frame busy length, per-frame idle gap (-1 = don't care).
    logic [1:0] eq0[$];
    logic [1:0] eq1[$];
    int         lq0[$];
    int         lq1[$];
    int         gq0[$];
    int         gq1[$];

    int vecs = 0;
    int errs = 0;

    int run[2];
    int gap[2];
    bit prev[2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int i, input int n, input int w, input logic [15:0] bits, input int g);
        logic [1:0] e;
        for (int k = n - 1; k >= 0; k--) begin
            e[1] = bits[k];
            e[0] = ((n - 1 - k) >= 1) && ((n - 1 - k) <= w);
            if (i == 0) eq0.push_back(e);
            else        eq1.push_back(e);
        end
        if (i == 0) begin lq0.push_back(n); gq0.push_back(g); end
        else        begin lq1.push_back(n); gq1.push_back(g); end
    endtask

    task automatic pop_exp(input int i, output bit ok, output logic [1:0] e);
        ok = 1'b0;
        e  = 2'b00;
        if (i == 0) begin
            if (eq0.size() > 0) begin e = eq0.pop_front(); ok = 1'b1; end
        end else begin
            if (eq1.size() > 0) begin e = eq1.pop_front(); ok = 1'b1; end
        end
    endtask

    task automatic pop_int(input int i, input int which, output bit ok, output int v);
        ok = 1'b0;
        v  = 0;
        if (i == 0 && which == 0 && lq0.size() > 0) begin v = lq0.pop_front(); ok = 1'b1; end
        if (i == 0 && which == 1 && gq0.size() > 0) begin v = gq0.pop_front(); ok = 1'b1; end
        if (i == 1 && which == 0 && lq1.size() > 0) begin v = lq1.pop_front(); ok = 1'b1; end
        if (i == 1 && which == 1 && gq1.size() > 0) begin v = gq1.pop_front(); ok = 1'b1; end
    endtask

    task automatic mon(input int i, input logic b, input logic tx, input logic sen);
        bit         ok;
        logic [1:0] e;
        int         v;
        string      tag;
        tag = (i == 0) ? "w8" : "w5";
        if (!rst) begin
            prev[i] = 1'b0;
            run[i]  = 0;
            gap[i]  = 0;
            return;
        end
        if (b) begin
            if (!prev[i]) begin
                pop_int(i, 1, ok, v);
                if (ok && v >= 0) check({tag, " idle_gap"}, gap[i], v);
                run[i] = 0;
            end
            run[i]++;
            pop_exp(i, ok, e);
            if (!ok) begin
                vecs++;
                errs++;
                $display("FAIL %s unexpected_busy: got busy=1 tx_out=%b expected idle at %0t", tag, tx, $time);
            end else begin
                check({tag, " tx_out"}, tx, e[1]);
                check({tag, " ser_en"}, sen, e[0]);
            end
        end else begin
            if (prev[i]) begin
                pop_int(i, 0, ok, v);
                if (!ok) begin
                    vecs++;
                    errs++;
                    $display("FAIL %s busy_len: got frame of %0d cycles expected none at %0t", tag, run[i], $time);
                end else begin
                    check({tag, " busy_len"}, run[i], v);
                end
                gap[i] = 0;
            end
            gap[i]++;
            check({tag, " idle_line"}, {tx, sen}, 2'b10);
        end
        prev[i] = b;
    endtask

    always @(negedge clk) mon(0, bus8.busy, bus8.tx_out, bus8.ser_en);
    always @(negedge clk) mon(1, bus5.busy, bus5.tx_out, bus5.ser_en);

    function automatic logic get_busy(input int i);
        return (i == 0) ? bus8.busy : bus5.busy;
    endfunction

    // Leaves the caller at posedge+1 with the selected DUT idle.
    task automatic wait_idle(input int i);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (get_busy(i) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            vecs++;
            errs++;
            $display("FAIL wait_idle: DUT %0d still busy after %0d cycles", i, n);
        end
    endtask

    task automatic drive(input int i, input logic dv, input logic [7:0] d, input logic pe, input logic pt);
        if (i == 0) begin
            bus8.data_valid = dv; bus8.p_data = d; bus8.par_en = pe; bus8.par_typ = pt;
        end else begin
            bus5.data_valid = dv; bus5.p_data = d[4:0]; bus5.par_en = pe; bus5.par_typ = pt;
        end
    endtask

    // One data_valid pulse; returns at accept edge + 1.
    task automatic send(input int i, input logic [7:0] d, input logic pe, input logic pt,
                        input int n, input int w, input logic [15:0] bits);
        wait_idle(i);
        push_frame(i, n, w, bits, -1);
        drive(i, 1'b1, d, pe, pt);
        @(posedge clk);
        #1;
        if (i == 0) bus8.data_valid = 1'b0;
        else        bus5.data_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        // Reset outputs appear without any clock edge.
        check("reset w8 tx_out", bus8.tx_out, 1'b1);
        check("reset w8 busy",   bus8.busy,   1'b0);
        check("reset w8 ser_en", bus8.ser_en, 1'b0);
        check("reset w5 tx_out", bus5.tx_out, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // A5, even parity: 0 10100101 0 1
        send(0, 8'hA5, 1'b1, 1'b0, 11, 8, 16'b01010010101);
        // A5, odd parity: parity bit flips to 1
        send(0, 8'hA5, 1'b1, 1'b1, 11, 8, 16'b01010010111);
        // FF, no parity: 10-cycle frame
        send(0, 8'hFF, 1'b0, 1'b0, 10, 8, 16'b0111111111);

        // data_valid held high: 3C even, then 81 odd picked up at the next accept
        wait_idle(0);
        push_frame(0, 11, 8, 16'b00011110001, -1);
        push_frame(0, 11, 8, 16'b01000000111, 1);
        drive(0, 1'b1, 8'h3C, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        bus8.p_data  = 8'h81;
        bus8.par_typ = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        bus8.data_valid = 1'b0;

        // Abort during DATA bit 4
        send(0, 8'hA5, 1'b1, 1'b0, 11, 8, 16'b01010010101);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        eq0.delete();
        lq0.delete();
        gq0.delete();
        #1;
        check("abort tx_out", bus8.tx_out, 1'b1);
        check("abort busy",   bus8.busy,   1'b0);
        check("abort ser_en", bus8.ser_en, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send(0, 8'hA5, 1'b1, 1'b1, 11, 8, 16'b01010010111);

        // WIDTH=5: 10011 even parity, then 00001 without parity after the counter wrap
        send(1, 8'h13, 1'b1, 1'b0, 8, 5, 16'b01100111);
        send(1, 8'h01, 1'b0, 1'b0, 7, 5, 16'b0100001);

        // Drain
        n = 0;
        while ((eq0.size() + eq1.size() > 0 || bus8.busy || bus5.busy) && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain w8 leftover", eq0.size() + lq0.size(), 0);
        check("drain w5 leftover", eq1.size() + lq1.size(), 0);
        check("w5 bit_cnt idle", dut5.bit_cnt, 0);
        check("w8 bit_cnt idle", dut8.bit_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
- Frame-sequencing controller for the parameterized UART transmitter. Sits beside the serializer and drives its shift enable.
- Accepts a parallel word on data_valid and computes its parity. Drives the TX line through start, data, optional parity and stop phases.
- The data bits come from the serializer output. One clock cycle = one bit period; a baud-rate strobe is applied upstream by gating clk/enable.

Parameters:
- WIDTH, 8, data word width in bits. Must be >= 2. Bit counter width is $clog2(WIDTH).

Ports:
- clk  input  1  system clock, all state updates on its rising edge
- rst  input  1  asynchronous active-low reset
- data_valid  input  1  request to transmit p_data; sampled only in IDLE
- p_data  input  WIDTH  parallel word, used only for the parity calculation at accept
- par_en  input  1  1 = insert parity bit; sampled at accept
- par_typ  input  1  0 = even parity, 1 = odd parity; sampled at accept
- ser_data  input  1  current serial data bit from the serializer (LSB first)
- ser_en  output  1  serializer shift enable, high for exactly WIDTH cycles per frame
- busy  output  1  high while a frame is in progress
- tx_out  output  1  UART line, idle high

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. The state register and bit counter are flops with async clear to IDLE / 0 on rst low.
- Reset values: state = IDLE, bit_cnt = 0, par_bit_r = 0, par_en_r = 0. This gives tx_out = 1, busy = 0, ser_en = 0 immediately on rst assertion, with no clock required.
- Accept (IDLE and data_valid = 1 at an edge):
  - Latch par_en_r = par_en.
  - Latch par_bit_r = (^p_data) XOR par_typ.
  - Next state = START.
- data_valid outside IDLE is ignored. There is no queuing and no back-to-back accept from STOP.
- START: lasts 1 cycle, then DATA with bit_cnt = 0.
- DATA: lasts WIDTH cycles.
  - ser_en = 1; bit_cnt increments each cycle.
  - When bit_cnt = WIDTH-1: go to PARITY if par_en_r, else STOP, and clear bit_cnt to 0.
- PARITY: lasts 1 cycle, then STOP.
- STOP: lasts 1 cycle, then IDLE. At least one IDLE cycle always separates frames.
- tx_out is a combinational mux of registered signals only:
  - IDLE = 1
  - START = 0
  - DATA = ser_data
  - PARITY = par_bit_r
  - STOP = 1
- busy = (state != IDLE), decoded from the state register.
- ser_en = (state == DATA).
- Serializer contract: ser_data presents bit k during the k-th DATA cycle. The serializer loads on the accept edge and shifts only on edges where ser_en = 1.
- Latency: tx_out falls (start bit) in the first cycle after the accept edge.
- Busy cycles per frame: WIDTH + 2 + par_en_r.
- p_data, par_en and par_typ changing mid-frame have no effect on the frame in progress.
- rst asserted mid-frame: the frame is aborted immediately and the line returns to 1. The first accept after rst deasserts starts a clean frame.
- bit_cnt never exceeds WIDTH-1. Unused state encodings decode to IDLE on the next edge.

Test Plan:
- WIDTH=8, p_data=8'hA5, par_en=1, par_typ=0, serializer model attached, one data_valid pulse:
  - tx_out = 0,1,0,1,0,0,1,0,1,0(parity),1(stop), then idle 1.
  - busy high exactly 11 cycles; ser_en high exactly 8 cycles.
- Same word with par_typ=1 -> parity bit = 1; all other bits unchanged.
- par_en=0, p_data=8'hFF -> 10-cycle frame 0,1,1,1,1,1,1,1,1,1; no PARITY state visited; busy high 10 cycles.
- data_valid held high continuously with p_data=8'h3C, par_en=1:
  - Frames repeat with exactly one IDLE cycle (tx_out=1, busy=0) between them.
  - Inputs changed mid-frame do not alter the current frame.
- rst pulsed low during DATA bit 4 -> tx_out=1, busy=0, ser_en=0 asynchronously. A next accept yields a complete correct frame.
- WIDTH=5, p_data=5'b10011, par_en=1, par_typ=0:
  - Frame 0,1,1,0,0,1,1(parity),1(stop).
  - bit_cnt wraps to 0 after 5 data cycles.
